complex_nr_mult_seq: RTL and testbench

COMPLEX_NR_MULT_SEQ -- requirements
Module: complex_nr_mult_seq

---
 rtl/complex_mult_pkg.sv | 20 ++
 rtl/cplx_shared_mult.sv | 22 ++
 rtl/complex_nr_mult_seq.sv | 197 +++++++++++++++++++
 tb/tb_complex_nr_mult_seq.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/complex_mult_pkg.sv
// Shared types and constants for the sequential complex multiplier.
package complex_mult_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_MULT   = 2'd1,
      ST_COMB   = 2'd2,
      ST_RESULT = 2'd3
   } state_e;

   localparam int unsigned MULT_STEPS = 4;

   // Which partial product the shared multiplier computes in each MULT step
   localparam logic [1:0] STEP_AC   = 2'd0;
   localparam logic [1:0] STEP_BD   = 2'd1;
   localparam logic [1:0] STEP_AD   = 2'd2;
   localparam logic [1:0] STEP_BC   = 2'd3;
   localparam logic [1:0] LAST_STEP = 2'(MULT_STEPS - 1);

endpackage

// File: rtl/cplx_shared_mult.sv
// Single combinational DATA_WIDTH x DATA_WIDTH multiplier, signed or unsigned.
module cplx_shared_mult #(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned SIGNED_MODE = 1
) (
   input  logic [DATA_WIDTH-1:0]   a_i,
   input  logic [DATA_WIDTH-1:0]   b_i,
   output logic [2*DATA_WIDTH-1:0] p_o
);

   localparam int unsigned PW  = 2 * DATA_WIDTH;
   localparam logic        SGN = 1'(SIGNED_MODE != 0);

   logic [PW-1:0] a_ext;
   logic [PW-1:0] b_ext;

   // Extending to the product width makes the truncated product exact in both modes
   assign a_ext = {{DATA_WIDTH{SGN & a_i[DATA_WIDTH-1]}}, a_i};
   assign b_ext = {{DATA_WIDTH{SGN & b_i[DATA_WIDTH-1]}}, b_i};
   assign p_o   = a_ext * b_ext;

endmodule

// File: rtl/complex_nr_mult_seq.sv
// Sequential complex multiplier: four partial products through one shared
// multiplier, then one combine cycle, then a held result with valid/ready.
module complex_nr_mult_seq
   import complex_mult_pkg::*;
#(
   parameter  int unsigned DATA_WIDTH  = 8,
   parameter  int unsigned SIGNED_MODE = 1,
   localparam int unsigned RES_WIDTH   = 2 * DATA_WIDTH + 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sw_rst,
   input  logic                  op_val,
   input  logic                  conj,
   input  logic [DATA_WIDTH-1:0] op_1_re,
   input  logic [DATA_WIDTH-1:0] op_1_im,
   input  logic [DATA_WIDTH-1:0] op_2_re,
   input  logic [DATA_WIDTH-1:0] op_2_im,
   input  logic                  res_ready,
   output logic                  op_ready,
   output logic                  res_val,
   output logic                  busy,
   output logic [RES_WIDTH-1:0]  result_re,
   output logic [RES_WIDTH-1:0]  result_im
);

   localparam int unsigned PW  = 2 * DATA_WIDTH;
   localparam logic        SGN = 1'(SIGNED_MODE != 0);

   state_e                state_q, state_d;
   logic [1:0]            step_q, step_d;
   logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
   logic                  conj_q, conj_d;
   logic [PW-1:0]         ac_q, ac_d, bd_q, bd_d, ad_q, ad_d, bc_q, bc_d;
   logic [RES_WIDTH-1:0]  re_q, re_d, im_q, im_d;
   logic                  op_ready_q, op_ready_d;
   logic                  res_val_q, res_val_d;
   logic                  busy_q, busy_d;

   logic [DATA_WIDTH-1:0] mul_x, mul_y;
   logic [PW-1:0]         mul_p;
   logic [RES_WIDTH-1:0]  ac_x, bd_x, ad_x, bc_x;

   // Select the operand pair for the current MULT step
   always_comb begin
      mul_x = a_q;
      mul_y = c_q;
      case (step_q)
         STEP_AC: begin mul_x = a_q; mul_y = c_q; end
         STEP_BD: begin mul_x = b_q; mul_y = d_q; end
         STEP_AD: begin mul_x = a_q; mul_y = d_q; end
         STEP_BC: begin mul_x = b_q; mul_y = c_q; end
      endcase
   end

   cplx_shared_mult #(
      .DATA_WIDTH  (DATA_WIDTH),
      .SIGNED_MODE (SIGNED_MODE)
   ) u_mult (
      .a_i (mul_x),
      .b_i (mul_y),
      .p_o (mul_p)
   );

   // Products widened to result width; two guard bits make the sums overflow-free
   assign ac_x = {{2{SGN & ac_q[PW-1]}}, ac_q};
   assign bd_x = {{2{SGN & bd_q[PW-1]}}, bd_q};
   assign ad_x = {{2{SGN & ad_q[PW-1]}}, ad_q};
   assign bc_x = {{2{SGN & bc_q[PW-1]}}, bc_q};

   // Next-state, datapath and registered-output logic
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      d_d     = d_q;
      conj_d  = conj_q;
      ac_d    = ac_q;
      bd_d    = bd_q;
      ad_d    = ad_q;
      bc_d    = bc_q;
      re_d    = re_q;
      im_d    = im_q;

      case (state_q)
         ST_IDLE: begin
            if (op_val) begin
               a_d     = op_1_re;
               b_d     = op_1_im;
               c_d     = op_2_re;
               d_d     = op_2_im;
               conj_d  = conj;
               step_d  = STEP_AC;
               state_d = ST_MULT;
            end
         end
         ST_MULT: begin
            case (step_q)
               STEP_AC: ac_d = mul_p;
               STEP_BD: bd_d = mul_p;
               STEP_AD: ad_d = mul_p;
               STEP_BC: bc_d = mul_p;
            endcase
            step_d = step_q + 2'd1;
            if (step_q == LAST_STEP) begin
               state_d = ST_COMB;
            end
         end
         ST_COMB: begin
            if (conj_q) begin
               re_d = ac_x + bd_x;
               im_d = bc_x - ad_x;
            end else begin
               re_d = ac_x - bd_x;
               im_d = ad_x + bc_x;
            end
            state_d = ST_RESULT;
         end
         ST_RESULT: begin
            if (res_val_q && res_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Software reset wins over any accept, handshake or operation in flight
      if (sw_rst) begin
         state_d = ST_IDLE;
         step_d  = '0;
         a_d     = '0;
         b_d     = '0;
         c_d     = '0;
         d_d     = '0;
         conj_d  = 1'b0;
         ac_d    = '0;
         bd_d    = '0;
         ad_d    = '0;
         bc_d    = '0;
         re_d    = '0;
         im_d    = '0;
      end

      // res_val rises one cycle after entering RESULT, giving the 6-cycle latency
      op_ready_d = (state_d == ST_IDLE);
      busy_d     = (state_d != ST_IDLE);
      res_val_d  = (state_q == ST_RESULT) && (state_d == ST_RESULT);
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         step_q     <= '0;
         a_q        <= '0;
         b_q        <= '0;
         c_q        <= '0;
         d_q        <= '0;
         conj_q     <= 1'b0;
         ac_q       <= '0;
         bd_q       <= '0;
         ad_q       <= '0;
         bc_q       <= '0;
         re_q       <= '0;
         im_q       <= '0;
         op_ready_q <= 1'b1;
         res_val_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         step_q     <= step_d;
         a_q        <= a_d;
         b_q        <= b_d;
         c_q        <= c_d;
         d_q        <= d_d;
         conj_q     <= conj_d;
         ac_q       <= ac_d;
         bd_q       <= bd_d;
         ad_q       <= ad_d;
         bc_q       <= bc_d;
         re_q       <= re_d;
         im_q       <= im_d;
         op_ready_q <= op_ready_d;
         res_val_q  <= res_val_d;
         busy_q     <= busy_d;
      end
   end

   assign op_ready  = op_ready_q;
   assign res_val   = res_val_q;
   assign busy      = busy_q;
   assign result_re = re_q;
   assign result_im = im_q;

endmodule

// File: tb/tb_complex_nr_mult_seq.sv
// Bench: signed and unsigned instances share stimulus; checked against an integer model.
module tb_complex_nr_mult_seq;

   logic        clk;
   logic        rst;
   logic        sw_rst;
   logic        op_val;
   logic        conj;
   logic [7:0]  op_1_re, op_1_im, op_2_re, op_2_im;
   logic        res_ready;

   logic        op_ready_s, res_val_s, busy_s;
   logic [17:0] re_s, im_s;
   logic        op_ready_u, res_val_u, busy_u;
   logic [17:0] re_u, im_u;

   int checks;
   int errors;

   typedef struct {
      logic [7:0] a, b, c, d;
      logic       cj;
      int         hold;
      int         re_s, im_s, re_u, im_u;
   } vec_t;

   vec_t vecs[6];

   complex_nr_mult_seq #(.DATA_WIDTH(8), .SIGNED_MODE(1)) u_dut_s (
      .clk(clk), .rst(rst), .sw_rst(sw_rst), .op_val(op_val), .conj(conj),
      .op_1_re(op_1_re), .op_1_im(op_1_im), .op_2_re(op_2_re), .op_2_im(op_2_im),
      .res_ready(res_ready), .op_ready(op_ready_s), .res_val(res_val_s),
      .busy(busy_s), .result_re(re_s), .result_im(im_s)
   );

   complex_nr_mult_seq #(.DATA_WIDTH(8), .SIGNED_MODE(0)) u_dut_u (
      .clk(clk), .rst(rst), .sw_rst(sw_rst), .op_val(op_val), .conj(conj),
      .op_1_re(op_1_re), .op_1_im(op_1_im), .op_2_re(op_2_re), .op_2_im(op_2_im),
      .res_ready(res_ready), .op_ready(op_ready_u), .res_val(res_val_u),
      .busy(busy_u), .result_re(re_u), .result_im(im_u)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Reference: complex product from plain integer arithmetic
   task automatic model(input logic [7:0] a, b, c, d, input logic cj, input bit sgn,
                        output int re, output int im);
      int ia, ib, ic, id;
      ia = sgn ? int'($signed(a)) : int'(a);
      ib = sgn ? int'($signed(b)) : int'(b);
      ic = sgn ? int'($signed(c)) : int'(c);
      id = sgn ? int'($signed(d)) : int'(d);
      if (cj) begin
         re = ia * ic + ib * id;
         im = ib * ic - ia * id;
      end else begin
         re = ia * ic - ib * id;
         im = ia * id + ib * ic;
      end
   endtask

   task automatic chk_results(input string tag, input int ers, eis, eru, eiu);
      chk({tag, "_re_s"}, int'($signed(re_s)), ers);
      chk({tag, "_im_s"}, int'($signed(im_s)), eis);
      chk({tag, "_re_u"}, int'($signed(re_u)), eru);
      chk({tag, "_im_u"}, int'($signed(im_u)), eiu);
   endtask

   task automatic run_op(input logic [7:0] a, b, c, d, input logic cj, input int hold,
                         input int ers, eis, eru, eiu);
      int n;
      int lat;
      n = 0;
      while (!op_ready_s && n < 20) begin
         tick();
         n++;
      end
      chk("op_ready_wait", int'(op_ready_s), 1);
      op_1_re = a; op_1_im = b; op_2_re = c; op_2_im = d; conj = cj;
      op_val = 1'b1;
      res_ready = (hold == 0);
      tick();
      // Scramble inputs after accept; result must come from the captured copy
      op_val  = 1'b0;
      op_1_re = 8'($urandom); op_1_im = 8'($urandom);
      op_2_re = 8'($urandom); op_2_im = 8'($urandom);
      conj    = ~cj;
      chk("busy_after_accept", int'(busy_s), 1);
      chk("op_ready_after_accept", int'(op_ready_s), 0);
      lat = 0;
      while (!res_val_s && lat < 20) begin
         tick();
         lat++;
      end
      chk("latency", lat, 6);
      chk("res_val_u", int'(res_val_u), 1);
      chk_results("res", ers, eis, eru, eiu);
      for (int i = 0; i < hold; i++) begin
         op_val = 1'b1;
         tick();
         chk("hold_res_val", int'(res_val_s), 1);
         chk("hold_op_ready", int'(op_ready_s), 0);
         chk_results("hold", ers, eis, eru, eiu);
      end
      op_val    = 1'b0;
      res_ready = 1'b1;
      tick();
      chk("post_hs_res_val", int'(res_val_s), 0);
      chk("post_hs_op_ready", int'(op_ready_s), 1);
   endtask

   initial begin
      int ers, eis, eru, eiu, cnt;
      logic [7:0] ra, rb, rc, rd;
      logic rcj;

      vecs[0] = '{8'd3,   8'd4,   8'd5,   8'd6,   1'b0, 0, -9, 38, -9, 38};
      vecs[1] = '{8'd3,   8'd4,   8'd5,   8'd6,   1'b1, 0, 39, 2, 39, 2};
      vecs[2] = '{8'h80,  8'h80,  8'h80,  8'h80,  1'b0, 0, 0, 32768, 0, 32768};
      vecs[3] = '{8'hFF,  8'hFF,  8'hFF,  8'hFF,  1'b0, 0, 0, 2, 0, 130050};
      vecs[4] = '{8'd1,   8'd1,   8'd1,   8'hFF,  1'b0, 0, 2, 0, -254, 256};
      vecs[5] = '{8'd3,   8'd4,   8'd5,   8'd6,   1'b0, 3, -9, 38, -9, 38};

      checks = 0; errors = 0;
      rst = 1'b0; sw_rst = 1'b0; op_val = 1'b0; conj = 1'b0; res_ready = 1'b1;
      op_1_re = '0; op_1_im = '0; op_2_re = '0; op_2_im = '0;
      #1 rst = 1'b1;
      #19;
      chk("rst_op_ready", int'(op_ready_s), 1);
      chk("rst_res_val", int'(res_val_s), 0);
      chk("rst_busy", int'(busy_s), 0);
      chk_results("rst", 0, 0, 0, 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Directed vectors
      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, vecs[i].cj, vecs[i].hold,
                vecs[i].re_s, vecs[i].im_s, vecs[i].re_u, vecs[i].im_u);
      end

      // Software reset at MULT step 2 aborts the operation
      op_1_re = 8'd9; op_1_im = 8'd2; op_2_re = 8'd7; op_2_im = 8'd3; conj = 1'b0;
      op_val = 1'b1;
      tick();
      op_val = 1'b0;
      tick();
      tick();
      sw_rst = 1'b1;
      tick();
      sw_rst = 1'b0;
      chk("swrst_op_ready", int'(op_ready_s), 1);
      chk("swrst_busy", int'(busy_s), 0);
      chk("swrst_res_val", int'(res_val_s), 0);
      chk_results("swrst", 0, 0, 0, 0);
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (res_val_s) cnt++;
      end
      chk("swrst_no_res_val", cnt, 0);
      run_op(8'd1, 8'd1, 8'd1, 8'hFF, 1'b0, 0, 2, 0, -254, 256);

      // Randomized operations against the model
      for (int k = 0; k < 24; k++) begin
         ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom); rd = 8'($urandom);
         rcj = 1'($urandom);
         model(ra, rb, rc, rd, rcj, 1'b1, ers, eis);
         model(ra, rb, rc, rd, rcj, 1'b0, eru, eiu);
         run_op(ra, rb, rc, rd, rcj, int'($urandom_range(0, 2)), ers, eis, eru, eiu);
      end

      // Asynchronous reset mid-COMB
      op_1_re = 8'd7; op_1_im = 8'd8; op_2_re = 8'd9; op_2_im = 8'd10; conj = 1'b0;
      op_val = 1'b1;
      tick();
      op_val = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      #2 rst = 1'b1;
      #1;
      chk("arst_op_ready", int'(op_ready_s), 1);
      chk("arst_res_val", int'(res_val_s), 0);
      chk("arst_busy", int'(busy_s), 0);
      chk_results("arst", 0, 0, 0, 0);
      #1 rst = 1'b0;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (res_val_s || busy_s) cnt++;
      end
      chk("arst_op_lost", cnt, 0);
      run_op(8'd3, 8'd4, 8'd5, 8'd6, 1'b1, 0, 39, 2, 39, 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
